// File: rtl/idli_pkg.sv
// Shared types and constants for the idli core and its SQI memory responder.
package idli_pkg;

    typedef enum logic [1:0] {
        SQI_MODE_IDLE,
        SQI_MODE_OUT,
        SQI_MODE_IN
    } sqi_mode_t;

    typedef enum logic [2:0] {
        SQI_MEM_IDLE,
        SQI_MEM_CMD,
        SQI_MEM_ADDR,
        SQI_MEM_DUMMY,
        SQI_MEM_RD_DATA,
        SQI_MEM_WR_DATA,
        SQI_MEM_IGNORE
    } sqi_mem_state_t;

    localparam logic [7:0] SQI_CMD_READ  = 8'h03;
    localparam logic [7:0] SQI_CMD_WRITE = 8'h02;

    localparam int unsigned SQI_ADDR_NIBBLES  = 6;
    localparam int unsigned SQI_DUMMY_NIBBLES = 2;

    // Nibble counter width, wide enough for the longest counted phase.
    localparam int unsigned SQI_CNT_W = 3;

endpackage

// File: rtl/idli_sqi_mem_ram_m.sv
// Byte-wide flop array with one synchronous write port and an asynchronous read port.
module idli_sqi_mem_ram_m
#(
    parameter int unsigned ADDR_W = 8
) (
    input  logic              i_ram_gck,
    input  logic              i_ram_wr_en,
    input  logic [ADDR_W-1:0] i_ram_wr_addr,
    input  logic [7:0]        i_ram_wr_data,
    input  logic [ADDR_W-1:0] i_ram_rd_addr,
    output logic [7:0]        o_ram_rd_data
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    // Contents survive reset by design, so the array has no reset.
    logic [7:0] mem [DEPTH];

    always_ff @(posedge i_ram_gck) begin
        if (i_ram_wr_en) begin
            mem[i_ram_wr_addr] <= i_ram_wr_data;
        end
    end

    assign o_ram_rd_data = mem[i_ram_rd_addr];

endmodule

// File: rtl/idli_sqi_mem_m.sv
// SQI serial-SRAM responder: decodes the core's nibble stream into READ/WRITE
// transactions against an internal byte array and returns read data nibble-serially.
module idli_sqi_mem_m
    import idli_pkg::*;
#(
    parameter int unsigned ADDR_W = 8
) (
    input  logic       i_mem_gck,
    input  logic       i_mem_rst_n,
    input  logic       i_mem_sqi_sck,
    input  logic       i_mem_sqi_cs,
    input  logic [3:0] i_mem_sqi_data,
    output logic [3:0] o_mem_sqi_data,
    output logic       o_mem_sqi_oe,
    output logic       o_mem_err
);

    localparam logic [SQI_CNT_W-1:0] ADDR_LAST  = SQI_CNT_W'(SQI_ADDR_NIBBLES - 1);
    localparam logic [SQI_CNT_W-1:0] DUMMY_LAST = SQI_CNT_W'(SQI_DUMMY_NIBBLES - 1);

    sqi_mem_state_t        state_q, state_d;
    logic [SQI_CNT_W-1:0]  cnt_q, cnt_d;
    logic [3:0]            cmd_hi_q, cmd_hi_d;
    logic                  is_rd_q, is_rd_d;
    logic [ADDR_W-1:0]     addr_q, addr_d;
    logic                  nib_lo_q, nib_lo_d;
    logic [3:0]            wr_hi_q, wr_hi_d;
    logic [3:0]            data_q, data_d;
    logic                  oe_q, oe_d;
    logic                  err_q, err_d;

    logic [7:0]            cmd_c;
    logic                  cmd_ok_c;
    logic [ADDR_W-1:0]     addr_inc_c;
    logic [ADDR_W-1:0]     rd_addr_c;
    logic [7:0]            rd_data_c;
    logic                  wr_en_c;

    assign cmd_c      = {cmd_hi_q, i_mem_sqi_data};
    assign cmd_ok_c   = (cmd_c == SQI_CMD_READ) || (cmd_c == SQI_CMD_WRITE);
    assign addr_inc_c = addr_q + ADDR_W'(1);
    // When the low nibble has just gone out, look ahead to the next byte.
    assign rd_addr_c  = (state_q == SQI_MEM_RD_DATA && !nib_lo_q) ? addr_inc_c : addr_q;

    idli_sqi_mem_ram_m #(
        .ADDR_W (ADDR_W)
    ) u_ram (
        .i_ram_gck     (i_mem_gck),
        .i_ram_wr_en   (wr_en_c),
        .i_ram_wr_addr (addr_q),
        .i_ram_wr_data ({wr_hi_q, i_mem_sqi_data}),
        .i_ram_rd_addr (rd_addr_c),
        .o_ram_rd_data (rd_data_c)
    );

    // State register.
    always_ff @(posedge i_mem_gck or negedge i_mem_rst_n) begin
        if (!i_mem_rst_n) begin
            state_q <= SQI_MEM_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        if (i_mem_sqi_cs) begin
            state_d = SQI_MEM_IDLE;
        end else if (i_mem_sqi_sck) begin
            case (state_q)
                SQI_MEM_IDLE:  state_d = SQI_MEM_CMD;
                SQI_MEM_CMD:   state_d = cmd_ok_c ? SQI_MEM_ADDR : SQI_MEM_IGNORE;
                SQI_MEM_ADDR: begin
                    if (cnt_q == ADDR_LAST) begin
                        state_d = is_rd_q ? SQI_MEM_DUMMY : SQI_MEM_WR_DATA;
                    end
                end
                SQI_MEM_DUMMY: begin
                    if (cnt_q == DUMMY_LAST) begin
                        state_d = SQI_MEM_RD_DATA;
                    end
                end
                default: state_d = state_q;
            endcase
        end
    end

    // Datapath and output next values.
    always_comb begin
        cnt_d    = cnt_q;
        cmd_hi_d = cmd_hi_q;
        is_rd_d  = is_rd_q;
        addr_d   = addr_q;
        nib_lo_d = nib_lo_q;
        wr_hi_d  = wr_hi_q;
        data_d   = data_q;
        oe_d     = oe_q;
        err_d    = err_q;
        wr_en_c  = 1'b0;

        if (i_mem_sqi_cs) begin
            cnt_d    = '0;
            nib_lo_d = 1'b0;
            oe_d     = 1'b0;
            err_d    = 1'b0;
        end else if (i_mem_sqi_sck) begin
            case (state_q)
                SQI_MEM_IDLE: begin
                    cmd_hi_d = i_mem_sqi_data;
                    cnt_d    = '0;
                end
                SQI_MEM_CMD: begin
                    is_rd_d = (cmd_c == SQI_CMD_READ);
                    err_d   = !cmd_ok_c;
                    cnt_d   = '0;
                end
                SQI_MEM_ADDR: begin
                    // Shift in MSB-first; upper address bits fall off the top.
                    addr_d   = ADDR_W'({addr_q, i_mem_sqi_data});
                    cnt_d    = (cnt_q == ADDR_LAST) ? '0 : SQI_CNT_W'(cnt_q + SQI_CNT_W'(1));
                    nib_lo_d = 1'b0;
                end
                SQI_MEM_DUMMY: begin
                    cnt_d = SQI_CNT_W'(cnt_q + SQI_CNT_W'(1));
                    if (cnt_q == DUMMY_LAST) begin
                        data_d   = rd_data_c[7:4];
                        oe_d     = 1'b1;
                        nib_lo_d = 1'b1;
                        cnt_d    = '0;
                    end
                end
                SQI_MEM_RD_DATA: begin
                    if (nib_lo_q) begin
                        data_d   = rd_data_c[3:0];
                        nib_lo_d = 1'b0;
                    end else begin
                        data_d   = rd_data_c[7:4];
                        addr_d   = addr_inc_c;
                        nib_lo_d = 1'b1;
                    end
                end
                SQI_MEM_WR_DATA: begin
                    if (nib_lo_q) begin
                        wr_en_c  = 1'b1;
                        addr_d   = addr_inc_c;
                        nib_lo_d = 1'b0;
                    end else begin
                        wr_hi_d  = i_mem_sqi_data;
                        nib_lo_d = 1'b1;
                    end
                end
                default: begin
                    err_d = 1'b1;
                end
            endcase
        end
    end

    // Datapath and output registers.
    always_ff @(posedge i_mem_gck or negedge i_mem_rst_n) begin
        if (!i_mem_rst_n) begin
            cnt_q    <= '0;
            cmd_hi_q <= '0;
            is_rd_q  <= 1'b0;
            addr_q   <= '0;
            nib_lo_q <= 1'b0;
            wr_hi_q  <= '0;
            data_q   <= '0;
            oe_q     <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            cmd_hi_q <= cmd_hi_d;
            is_rd_q  <= is_rd_d;
            addr_q   <= addr_d;
            nib_lo_q <= nib_lo_d;
            wr_hi_q  <= wr_hi_d;
            data_q   <= data_d;
            oe_q     <= oe_d;
            err_q    <= err_d;
        end
    end

    assign o_mem_sqi_data = data_q;
    assign o_mem_sqi_oe   = oe_q;
    assign o_mem_err      = err_q;

endmodule

// File: tb/tb_idli_sqi_mem_m.sv
// Directed bench for the SQI memory responder: writes, reads, wrap, abort, bad command, stall, reset.
module tb_idli_sqi_mem_m;

    logic       gck;
    logic       rst_n;
    logic       sck;
    logic       cs;
    logic [3:0] din;
    logic [3:0] dout;
    logic       oe;
    logic       err;

    int n_tests = 0;
    int n_fail  = 0;

    idli_sqi_mem_m #(
        .ADDR_W (8)
    ) dut (
        .i_mem_gck      (gck),
        .i_mem_rst_n    (rst_n),
        .i_mem_sqi_sck  (sck),
        .i_mem_sqi_cs   (cs),
        .i_mem_sqi_data (din),
        .o_mem_sqi_data (dout),
        .o_mem_sqi_oe   (oe),
        .o_mem_err      (err)
    );

    initial gck = 1'b0;
    always #5 gck = ~gck;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic xfer(input logic [3:0] nib);
        @(negedge gck);
        cs  = 1'b0;
        sck = 1'b1;
        din = nib;
        @(posedge gck);
        #1;
    endtask

    task automatic stall();
        @(negedge gck);
        sck = 1'b0;
        @(posedge gck);
        #1;
    endtask

    task automatic deselect();
        @(negedge gck);
        cs  = 1'b1;
        sck = 1'b0;
        @(posedge gck);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        xfer(b[7:4]);
        xfer(b[3:0]);
    endtask

    task automatic start(input logic [7:0] cmd, input logic [23:0] addr);
        send_byte(cmd);
        send_byte(addr[23:16]);
        send_byte(addr[15:8]);
        send_byte(addr[7:0]);
    endtask

    task automatic write_bytes(input logic [23:0] addr, input logic [15:0] d);
        start(8'h02, addr);
        send_byte(d[15:8]);
        send_byte(d[7:0]);
        deselect();
    endtask

    // Reads two bytes; the first nibble is checked right after the 2nd dummy.
    task automatic read_bytes(input string tag, input logic [23:0] addr, input logic [15:0] exp);
        start(8'h03, addr);
        xfer(4'h0);
        check({tag, "_dummy1_oe"}, 32'(oe), 32'(1'b0));
        xfer(4'h0);
        check({tag, "_oe"}, 32'(oe), 32'(1'b1));
        check({tag, "_n0"}, 32'(dout), 32'(exp[15:12]));
        xfer(4'h0);
        check({tag, "_n1"}, 32'(dout), 32'(exp[11:8]));
        xfer(4'h0);
        check({tag, "_n2"}, 32'(dout), 32'(exp[7:4]));
        xfer(4'h0);
        check({tag, "_n3"}, 32'(dout), 32'(exp[3:0]));
        deselect();
        check({tag, "_oe_drop"}, 32'(oe), 32'(1'b0));
    endtask

    initial begin
        rst_n = 1'b0;
        cs    = 1'b1;
        sck   = 1'b0;
        din   = 4'h0;
        #1;
        check("reset_data", 32'(dout), 32'h0);
        check("reset_oe",   32'(oe),   32'h0);
        check("reset_err",  32'(err),  32'h0);
        repeat (2) @(posedge gck);
        @(negedge gck);
        rst_n = 1'b1;

        // Write then read back.
        write_bytes(24'h000010, 16'hA53C);
        read_bytes("wr_rd", 24'h000010, 16'hA53C);

        // Address wrap 0xFF -> 0x00.
        write_bytes(24'h0000FF, 16'h1122);
        read_bytes("wrap", 24'h0000FF, 16'h1122);

        // Partial write abort: the half byte for 0x06 is dropped.
        write_bytes(24'h000006, 16'hE100);
        start(8'h02, 24'h000005);
        send_byte(8'h77);
        xfer(4'h9);
        deselect();
        read_bytes("abort", 24'h000005, 16'h77E1);

        // Unsupported command is ignored with err raised.
        send_byte(8'h9F);
        check("bad_err", 32'(err), 32'h1);
        check("bad_oe",  32'(oe),  32'h0);
        for (int i = 0; i < 8; i++) begin
            xfer(4'(i));
            check("bad_hold_err", 32'(err), 32'h1);
            check("bad_hold_oe",  32'(oe),  32'h0);
        end
        deselect();
        check("bad_err_clear", 32'(err), 32'h0);
        read_bytes("after_bad", 24'h000010, 16'hA53C);

        // Stall mid-read, then reset mid-read.
        start(8'h03, 24'h000010);
        xfer(4'h0);
        xfer(4'h0);
        check("stall_n0", 32'(dout), 32'hA);
        xfer(4'h0);
        check("stall_n1", 32'(dout), 32'h5);
        for (int i = 0; i < 3; i++) begin
            stall();
            check("stall_hold", 32'(dout), 32'h5);
            check("stall_oe",   32'(oe),   32'h1);
        end
        @(negedge gck);
        rst_n = 1'b0;
        #1;
        check("rst_mid_data", 32'(dout), 32'h0);
        check("rst_mid_oe",   32'(oe),   32'h0);
        cs  = 1'b1;
        sck = 1'b0;
        @(posedge gck);
        @(negedge gck);
        rst_n = 1'b1;
        read_bytes("post_rst", 24'h000010, 16'hA53C);
        read_bytes("post_rst_wrap", 24'h0000FF, 16'h1122);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/idli_sqi_mem_m.md
# idli_sqi_mem_m

Synthesisable SQI serial-SRAM responder: the memory end of the core's SQI bus. It decodes the nibble stream driven by the core (chip select, clock qualifier, 4-bit data) into READ/WRITE commands, stores bytes in an internal array, and returns read data nibble-serially. Used as the simulation and FPGA memory model behind the core, and the reference for SQI protocol compliance.

## Interface
- `ADDR_W`, default 8: byte-address bits kept internally; depth is 2^ADDR_W bytes.
- `i_mem_gck`  in  1  core clock, the only clock.
- `i_mem_rst_n`  in  1  asynchronous, active-low reset.
- `i_mem_sqi_sck`  in  1  SQI clock from the core; a high level qualifies a transfer cycle.
- `i_mem_sqi_cs`  in  1  chip select, active low (low = selected).
- `i_mem_sqi_data`  in  4  nibble driven by the core.
- `o_mem_sqi_data`  out  4  nibble returned to the core.
- `o_mem_sqi_oe`  out  1  responder is driving `o_mem_sqi_data`; core must be in receive mode.
- `o_mem_err`  out  1  high while an unsupported command is being ignored.

## Operation
- Transfer cycle: a gck rising edge with `i_mem_sqi_cs`=0 and `i_mem_sqi_sck`=1. One nibble moves per transfer cycle. Nibbles are MSB-first: high nibble of each byte first.
- States:
  - IDLE: entered on reset or on any cycle with cs=1. On a transfer cycle go to CMD.
  - CMD: 2 nibbles, with the first taken in IDLE→CMD. 0x03 → ADDR (read). 0x02 → ADDR (write). Any other value → IGNORE.
  - ADDR: 6 nibbles, 24-bit address. Only the low ADDR_W bits are kept; upper bits are discarded silently. Read → DUMMY. Write → WR_DATA.
  - DUMMY: 2 nibbles; input is ignored. On the 2nd dummy transfer, load the high nibble of mem[addr] into `o_mem_sqi_data` and set `o_mem_sqi_oe`=1. Then go to RD_DATA.
  - RD_DATA: each transfer cycle advances the output to the next nibble. After a low nibble, the address increments and the next byte's high nibble is presented.
  - WR_DATA: a high nibble is held in a staging register. The byte is written to mem[addr] on its low-nibble transfer, then the address increments.
  - IGNORE: `o_mem_err`=1; all transfers are ignored until cs=1.
- Address increment wraps 2^ADDR_W-1 → 0, for both read and write.
- cs=1 at any point forces IDLE, clears `o_mem_sqi_oe` and `o_mem_err`, and discards any partially assembled command, address or byte. A half-received write byte is never committed.
- A read of a location never written returns X in simulation. The array is not reset.
- Reset mid-transaction behaves as cs deassertion. Memory contents are preserved.

## Timing
- Reset values: `o_mem_sqi_data`=0, `o_mem_sqi_oe`=0, `o_mem_err`=0; state IDLE.
- All outputs are registered on gck. A nibble presented after transfer k is what the core samples on transfer k+1.
- Read latency: first data nibble is valid the cycle after the 2nd dummy transfer, i.e. after 10 transfers from the start of the command.
- Write commit: mem is updated on the gck edge of the low-nibble transfer. A read in the same transaction window sees the new value from the next cycle.
- Cycles with sck=0 and cs=0 hold all state and outputs.
- cs rising (deasserting): `o_mem_sqi_oe` and `o_mem_err` drop on the next gck edge.

## Structure
- The following belong in idli_pkg, next to sqi_mode_t:
  - `sqi_mem_state_t` (IDLE, CMD, ADDR, DUMMY, RD_DATA, WR_DATA, IGNORE).
  - `SQI_CMD_READ`=8'h03 and `SQI_CMD_WRITE`=8'h02.
  - `SQI_ADDR_NIBBLES`=6 and `SQI_DUMMY_NIBBLES`=2.
- One sub-module, `idli_sqi_mem_ram_m`: a 2^ADDR_W x 8 flop array with a single write port and an asynchronous read port.
- The top level holds the FSM, the nibble counter, the address register, the write staging nibble and the output register.

## Test plan
- Write, then read: cmd 02, addr 000010, data A5 3C; deassert cs; then cmd 03, addr 000010, dummy 2 nibbles. Expect 4 read nibbles A,5,3,C, with `o_mem_sqi_oe`=1 from the cycle after the 2nd dummy.
- Wrap: write 11 22 at addr 0000FF (ADDR_W=8). Expect mem[FF]=11 and mem[00]=22. Read from 0000FF returns 1,1,2,2.
- Partial write abort: write cmd, addr 000005, full byte 77, then only the high nibble 9; cs=1. Expect read of 05/06 = 77/unchanged; the half byte is dropped.
- Bad command: cmd 0x9F. Expect `o_mem_err`=1 and `o_mem_sqi_oe`=0 through the following 8 transfers. cs=1 clears err next cycle, and a following valid read works.
- Stall and reset: in a read, hold sck=0 for 3 cycles, output nibble unchanged. Assert rst_n=0 mid-read: outputs are 0 immediately. After reset, a read of previously written data still returns the stored values.
